// File: rtl/tsp_pkg.sv
// Shared definitions for the TSP instruction sequencer: opcodes, FSM states
// and instruction field positions.
package tsp_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int IMM_MSB = 15;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_VXM  = 4'd1,
        OP_SYNC = 4'd2,
        OP_JMP  = 4'd3,
        OP_HALT = 4'd4
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        STALL  = 3'd3,
        ISSUE  = 3'd4,
        SYNC   = 3'd5,
        DONE   = 3'd6
    } state_e;

    function automatic logic [3:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/tsp_instr_sequencer.sv
// Fetches instructions from the TSP instruction SRAM, issues VXM ops over a
// valid/ready handshake and executes NOP/SYNC/JMP/HALT locally.
module tsp_instr_sequencer
    import tsp_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    input  logic               abort,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               issue_valid,
    output logic [INSTR_W-1:0] issue_instr,
    input  logic               issue_ready,
    input  logic               unit_idle,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IMEM_AW-1:0] pc
);

    state_e             r_state;
    logic [IMEM_AW-1:0] r_pc;
    logic               r_imem_en;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic               r_issue_valid;
    logic [INSTR_W-1:0] r_issue_instr;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [IMM_MSB:0]   r_stall_cnt;
    logic               r_abort_pend;

    logic [IMEM_AW-1:0] w_pc_inc;
    logic [3:0]         w_opcode;
    logic [IMM_MSB:0]   w_imm;
    logic [IMEM_AW-1:0] w_jmp_target;

    assign w_pc_inc     = r_pc + IMEM_AW'(1);
    assign w_opcode     = opcode_of(imem_rdata[31:0]);
    assign w_imm        = imem_rdata[IMM_MSB:0];
    assign w_jmp_target = imem_rdata[IMEM_AW-1:0];

    // imem_en and done are one-cycle strobes: they default low every cycle and
    // are raised only on the transition into FETCH or DONE respectively.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_imem_en     <= 1'b0;
            r_imem_addr   <= '0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_stall_cnt   <= '0;
            r_abort_pend  <= 1'b0;
        end else begin
            r_imem_en <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pc        <= start_pc;
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_imem_en   <= 1'b1;
                        r_imem_addr <= start_pc;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        case (w_opcode)
                            OP_NOP: begin
                                if (w_imm == '0) begin
                                    r_pc        <= w_pc_inc;
                                    r_imem_en   <= 1'b1;
                                    r_imem_addr <= w_pc_inc;
                                    r_state     <= FETCH;
                                end else begin
                                    r_stall_cnt <= w_imm;
                                    r_state     <= STALL;
                                end
                            end
                            OP_VXM: begin
                                r_issue_instr <= imem_rdata;
                                r_issue_valid <= 1'b1;
                                r_abort_pend  <= 1'b0;
                                r_state       <= ISSUE;
                            end
                            OP_SYNC: begin
                                r_state <= SYNC;
                            end
                            OP_JMP: begin
                                r_pc        <= w_jmp_target;
                                r_imem_en   <= 1'b1;
                                r_imem_addr <= w_jmp_target;
                                r_state     <= FETCH;
                            end
                            OP_HALT: begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                            default: begin
                                r_error <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                        endcase
                    end
                end
                STALL: begin
                    r_stall_cnt <= r_stall_cnt - 1'b1;
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_stall_cnt == 16'd1) begin
                        r_pc        <= w_pc_inc;
                        r_imem_en   <= 1'b1;
                        r_imem_addr <= w_pc_inc;
                        r_state     <= FETCH;
                    end
                end
                ISSUE: begin
                    // An abort seen while stalled on ready is remembered and
                    // honoured once the handshake finally completes.
                    if (issue_ready) begin
                        r_issue_valid <= 1'b0;
                        if (abort || r_abort_pend) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_pc        <= w_pc_inc;
                            r_imem_en   <= 1'b1;
                            r_imem_addr <= w_pc_inc;
                            r_state     <= FETCH;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                SYNC: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (unit_idle) begin
                        r_pc        <= w_pc_inc;
                        r_imem_en   <= 1'b1;
                        r_imem_addr <= w_pc_inc;
                        r_state     <= FETCH;
                    end
                end
                DONE: begin
                    r_busy       <= 1'b0;
                    r_abort_pend <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_en     = r_imem_en;
    assign imem_addr   = r_imem_addr;
    assign issue_valid = r_issue_valid;
    assign issue_instr = r_issue_instr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign pc          = r_pc;

endmodule

// File: tb/tb_tsp_instr_sequencer.sv
// Self-checking bench for tsp_instr_sequencer: single-instruction vector table,
// directed corner sequences and random programs against an instruction-level model.
module tb_tsp_instr_sequencer;

    localparam int AW = 8;
    localparam int IW = 32;
    localparam logic [31:0] HALT_W = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          abort = 1'b0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          issue_valid;
    logic [IW-1:0] issue_instr;
    logic          issue_ready = 1'b1;
    logic          unit_idle = 1'b1;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] pc;

    tsp_instr_sequencer #(.IMEM_AW(AW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .abort(abort),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .unit_idle(unit_idle), .busy(busy), .done(done), .error(error), .pc(pc)
    );

    always #5 clk = ~clk;

    // Instruction SRAM with a one-cycle registered read
    logic [31:0] mem [256];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: cumulative traces, callers remember start indices
    logic [7:0]  obs_fetch[$];
    int          obs_fetch_t[$];
    logic [31:0] obs_issue[$];
    int          obs_issue_t[$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    always @(negedge clk) begin
        if (imem_en) begin
            obs_fetch.push_back(imem_addr);
            obs_fetch_t.push_back(cyc);
        end
        if (issue_valid && issue_ready) begin
            obs_issue.push_back(issue_instr);
            obs_issue_t.push_back(cyc);
        end
        if (issue_valid) valid_cnt++;
        if (done) done_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;
    int f0, i0, d0, v0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        f0 = obs_fetch.size();
        i0 = obs_issue.size();
        d0 = done_cnt;
        v0 = valid_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done, then one more cycle so the DUT is back in IDLE
    task automatic wait_done(input bit rnd, inout int lat);
        while (!done && lat < 3000) begin
            if (rnd) begin
                issue_ready = 1'($urandom_range(0, 1));
                unit_idle   = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done, want done within 3000 cycles");
        end
        issue_ready = 1'b1;
        unit_idle   = 1'b1;
        tick();
    endtask

    task automatic run(input logic [7:0] spc, input bit rnd, output int lat);
        start_pc    = spc;
        start       = 1'b1;
        issue_ready = 1'b1;
        unit_idle   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        wait_done(rnd, lat);
    endtask

    // Instruction-level reference: walks the program and predicts traces
    logic [7:0]  exp_fetch[$];
    logic [31:0] exp_issue[$];
    logic [7:0]  exp_pc;
    logic        exp_err;
    int          exp_lat;

    task automatic model(input logic [7:0] spc);
        logic [7:0]  p;
        logic [31:0] w;
        bit          fin;
        p = spc;
        fin = 1'b0;
        exp_fetch.delete();
        exp_issue.delete();
        exp_err = 1'b0;
        exp_lat = 1;
        for (int s = 0; s < 200 && !fin; s++) begin
            exp_fetch.push_back(p);
            w = mem[p];
            case (w[31:28])
                4'd0: begin exp_lat += 2 + int'(w[15:0]); p = p + 8'd1; end
                4'd1: begin exp_issue.push_back(w); exp_lat += 3; p = p + 8'd1; end
                4'd2: begin exp_lat += 3; p = p + 8'd1; end
                4'd3: begin exp_lat += 2; p = w[7:0]; end
                4'd4: begin exp_lat += 2; fin = 1'b1; end
                default: begin exp_lat += 2; exp_err = 1'b1; fin = 1'b1; end
            endcase
        end
        exp_pc = p;
    endtask

    task automatic gen_prog(input logic [7:0] base);
        for (int i = 0; i < 11; i++) begin
            int          r;
            int          t;
            logic [31:0] rr;
            logic [31:0] w;
            r  = $urandom_range(0, 19);
            rr = $urandom;
            if (r < 7)       w = {4'h0, rr[27:16], 14'd0, rr[1:0]};
            else if (r < 13) w = {4'h1, rr[27:0]};
            else if (r < 16) w = {4'h2, rr[27:0]};
            else if (r < 19) begin
                t = i + 1 + int'(rr[1:0]);
                if (t > 11) t = 11;
                w = {4'h3, rr[27:8], base + 8'(t)};
            end else         w = {4'($urandom_range(5, 15)), rr[27:0]};
            mem[base + 8'(i)] = w;
        end
        mem[base + 8'd11] = {4'h4, 28'($urandom)};
    endtask

    typedef struct {
        logic [31:0] instr;
        int          lat;
        logic        err;
        int          nissue;
        logic [7:0]  epc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int lat;
        bit ok;

        tbl[0] = '{32'h4000_0000, 3, 1'b0, 0, 8'h10};
        tbl[1] = '{32'h0000_0000, 5, 1'b0, 0, 8'h11};
        tbl[2] = '{32'h0000_0003, 8, 1'b0, 0, 8'h11};
        tbl[3] = '{32'h0ABC_0002, 7, 1'b0, 0, 8'h11};
        tbl[4] = '{32'h1000_00AA, 6, 1'b0, 1, 8'h11};
        tbl[5] = '{32'h2000_0000, 6, 1'b0, 0, 8'h11};
        tbl[6] = '{32'h3FFF_FF15, 5, 1'b0, 0, 8'h15};
        tbl[7] = '{32'h5000_0000, 3, 1'b1, 0, 8'h10};
        tbl[8] = '{32'hF123_4567, 3, 1'b1, 0, 8'h10};

        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_imem_en", 32'(imem_en), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-instruction vectors, ready/idle always high
        mem[8'h11] = HALT_W;
        mem[8'h15] = HALT_W;
        for (int k = 0; k < 9; k++) begin
            mem[8'h10] = tbl[k].instr;
            snap();
            run(8'h10, 1'b0, lat);
            $display("vec %0d instr=%08h lat=%0d pc=%02h err=%0d", k, tbl[k].instr, lat, pc, error);
            chk("vec_lat", 32'(lat), 32'(tbl[k].lat));
            chk("vec_err", 32'(error), 32'(tbl[k].err));
            chk("vec_pc", 32'(pc), 32'(tbl[k].epc));
            chk("vec_nissue", 32'(obs_issue.size() - i0), 32'(tbl[k].nissue));
            chk("vec_done_once", 32'(done_cnt - d0), 1);
            chk("vec_busy_after", 32'(busy), 0);
            if (tbl[k].nissue == 1 && obs_issue.size() > i0)
                chk("vec_issue_word", obs_issue[i0], tbl[k].instr);
        end

        // Two back-to-back VXM ops then HALT
        mem[0] = 32'h1000_00AA;
        mem[1] = 32'h1000_00BB;
        mem[2] = HALT_W;
        snap();
        run(8'h00, 1'b0, lat);
        $display("seq vxm2 issues=%0d", obs_issue.size() - i0);
        chk("vxm2_count", 32'(obs_issue.size() - i0), 2);
        if (obs_issue.size() - i0 == 2) begin
            chk("vxm2_word0", obs_issue[i0], 32'h1000_00AA);
            chk("vxm2_word1", obs_issue[i0 + 1], 32'h1000_00BB);
            chk("vxm2_spacing", 32'(obs_issue_t[i0 + 1] - obs_issue_t[i0]), 3);
        end
        chk("vxm2_done_once", 32'(done_cnt - d0), 1);
        chk("vxm2_busy_after", 32'(busy), 0);

        // NOP imm16=5: 7 cycles from its fetch to the next fetch
        mem[8'h60] = 32'h0000_0005;
        mem[8'h61] = HALT_W;
        snap();
        run(8'h60, 1'b0, lat);
        $display("seq nop5 fetches=%0d", obs_fetch.size() - f0);
        chk("nop5_fetches", 32'(obs_fetch.size() - f0), 2);
        if (obs_fetch.size() - f0 == 2)
            chk("nop5_span", 32'(obs_fetch_t[f0 + 1] - obs_fetch_t[f0]), 7);
        chk("nop5_no_valid", 32'(valid_cnt - v0), 0);

        // VXM held off by ready for 10 cycles, abort raised meanwhile
        mem[8'h20] = 32'h1000_0CCC;
        mem[8'h21] = HALT_W;
        snap();
        start_pc = 8'h20;
        start = 1'b1;
        issue_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !issue_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 2) abort = 1'b1;
            chk("hold_valid", 32'(issue_valid), 1);
            chk("hold_instr", issue_instr, 32'h1000_0CCC);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        chk("abort_issue_done", 32'(done), 1);
        chk("abort_issue_valid_low", 32'(issue_valid), 0);
        abort = 1'b0;
        tick();
        tick();
        tick();
        $display("seq abort_in_issue fetches=%0d busy=%0d", obs_fetch.size() - f0, busy);
        chk("abort_issue_idle", 32'(busy), 0);
        chk("abort_issue_nofetch", 32'(obs_fetch.size() - f0), 1);
        chk("abort_issue_done_once", 32'(done_cnt - d0), 1);

        // SYNC waits on unit_idle
        mem[8'h30] = 32'h2000_0000;
        mem[8'h31] = HALT_W;
        start_pc = 8'h30;
        start = 1'b1;
        unit_idle = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("sync_pc_hold", 32'(pc), 32'h30);
            chk("sync_no_fetch", 32'(imem_en), 0);
            tick();
        end
        unit_idle = 1'b1;
        chk("sync_pc_hold", 32'(pc), 32'h30);
        tick();
        $display("seq sync pc=%02h imem_en=%0d", pc, imem_en);
        chk("sync_pc_next", 32'(pc), 32'h31);
        chk("sync_fetch", 32'(imem_en), 1);
        chk("sync_fetch_addr", 32'(imem_addr), 32'h31);
        lat = 0;
        wait_done(1'b0, lat);

        // Illegal opcode at address 3, then error cleared by a new start
        mem[3] = 32'hF000_0000;
        snap();
        run(8'h03, 1'b0, lat);
        $display("seq illegal pc=%02h err=%0d", pc, error);
        chk("illegal_error", 32'(error), 1);
        chk("illegal_pc", 32'(pc), 3);
        chk("illegal_done_once", 32'(done_cnt - d0), 1);
        mem[8'h40] = HALT_W;
        start_pc = 8'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("error_cleared", 32'(error), 0);
        lat = 0;
        wait_done(1'b0, lat);

        // PC wrap from 0xFF to 0x00
        mem[8'hFF] = 32'h0000_0000;
        mem[8'h00] = HALT_W;
        snap();
        run(8'hFF, 1'b0, lat);
        $display("seq wrap pc=%02h", pc);
        chk("wrap_pc", 32'(pc), 0);
        chk("wrap_err", 32'(error), 0);
        if (obs_fetch.size() - f0 == 2) begin
            chk("wrap_fetch0", 32'(obs_fetch[f0]), 32'hFF);
            chk("wrap_fetch1", 32'(obs_fetch[f0 + 1]), 32'h00);
        end else begin
            chk("wrap_fetch_count", 32'(obs_fetch.size() - f0), 2);
        end

        // start and abort together in IDLE
        snap();
        start_pc = 8'h40;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        chk("startabort_busy", 32'(busy), 1);
        tick();
        chk("startabort_done", 32'(done), 1);
        abort = 1'b0;
        tick();
        $display("seq start_abort busy=%0d", busy);
        chk("startabort_idle", 32'(busy), 0);
        chk("startabort_fetches", 32'(obs_fetch.size() - f0), 1);

        // Start ignored while busy, then async reset mid-STALL
        mem[8'h50] = 32'h0000_0014;
        start_pc = 8'h50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        start_pc = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", 32'(pc), 32'h50);
        chk("busy_still", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        $display("seq reset_mid_stall busy=%0d pc=%02h", busy, pc);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_imem_en", 32'(imem_en), 0);
        chk("arst_imem_addr", 32'(imem_addr), 0);
        chk("arst_issue_valid", 32'(issue_valid), 0);
        chk("arst_issue_instr", issue_instr, 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_error", 32'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_stays_idle", 32'(busy), 0);

        // Random programs against the instruction-level model
        for (int it = 0; it < 30; it++) begin
            logic [7:0] base;
            bit         rnd;
            base = 8'($urandom_range(0, 255));
            rnd  = it[0];
            gen_prog(base);
            model(base);
            snap();
            run(base, rnd, lat);
            $display("rnd %0d base=%02h rnd=%0d issues=%0d fetches=%0d lat=%0d", it, base, rnd,
                     obs_issue.size() - i0, obs_fetch.size() - f0, lat);
            chk("rnd_nissue", 32'(obs_issue.size() - i0), 32'(exp_issue.size()));
            chk("rnd_nfetch", 32'(obs_fetch.size() - f0), 32'(exp_fetch.size()));
            ok = 1'b1;
            for (int j = 0; j < exp_issue.size() && i0 + j < obs_issue.size(); j++)
                if (obs_issue[i0 + j] !== exp_issue[j]) ok = 1'b0;
            chk("rnd_issue_words", 32'(ok), 1);
            ok = 1'b1;
            for (int j = 0; j < exp_fetch.size() && f0 + j < obs_fetch.size(); j++)
                if (obs_fetch[f0 + j] !== exp_fetch[j]) ok = 1'b0;
            chk("rnd_fetch_addrs", 32'(ok), 1);
            chk("rnd_pc", 32'(pc), 32'(exp_pc));
            chk("rnd_err", 32'(error), 32'(exp_err));
            chk("rnd_done_once", 32'(done_cnt - d0), 1);
            chk("rnd_busy_after", 32'(busy), 0);
            if (!rnd) chk("rnd_lat", 32'(lat), 32'(exp_lat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
